// File: rtl/interrupt_ctrl_if.sv
// rtl/interrupt_ctrl_if.sv - CPU bus and interrupt dispatch handshake between CPU core and interrupt_ctrl
interface interrupt_ctrl_if;
    logic [15:0] a;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic        rd;
    logic        wr;
    logic        int_req;
    logic [7:0]  int_vector;
    logic        int_cpu_ack;

    modport master (
        output a, din, rd, wr, int_cpu_ack,
        input  dout, int_req, int_vector
    );

    modport slave (
        input  a, din, rd, wr, int_cpu_ack,
        output dout, int_req, int_vector
    );
endinterface

// File: rtl/interrupt_ctrl.sv
// rtl/interrupt_ctrl.sv - IF/IE registers, source capture with ack pulses, priority arbiter and dispatch FSM
module interrupt_ctrl #(
    parameter logic [15:0] IF_ADDR     = 16'hFF0F,
    parameter logic [15:0] IE_ADDR     = 16'hFFFF,
    parameter logic [7:0]  VECTOR_BASE = 8'h40,
    parameter logic [7:0]  VECTOR_STEP = 8'h08
) (
    input  logic                  clk,
    input  logic                  rst,
    interrupt_ctrl_if.slave       bus,
    input  logic [4:0]            irq_src,
    output logic [4:0]            irq_ack
);

    typedef enum logic [1:0] {IDLE, ARMED, HOLD} state_t;

    state_t      state_q, state_d;
    logic [4:0]  if_q, if_d;
    logic [7:0]  ie_q, ie_d;
    logic [4:0]  ack_q, ack_d;
    logic        int_req_q, int_req_d;
    logic [7:0]  vec_q, vec_d;

    logic [4:0]  set;
    logic [4:0]  clr;
    logic [4:0]  pend;
    logic [4:0]  win_oh;
    logic [2:0]  win_idx;
    logic [7:0]  win_vec;
    logic        if_wr;
    logic        ie_wr;
    logic        unused_rd;

    assign unused_rd = bus.rd;
    assign if_wr     = bus.wr && (bus.a == IF_ADDR);
    assign ie_wr     = bus.wr && (bus.a == IE_ADDR);

    // Masking with the previous ack keeps a held level from being captured on back-to-back cycles.
    assign set   = irq_src & ~ack_q;
    assign ack_d = set;
    assign pend  = if_q & ie_q[4:0];

    always_comb begin
        win_idx = 3'd0;
        win_oh  = 5'd0;
        for (int i = 4; i >= 0; i--) begin
            if (pend[i]) begin
                win_idx = i[2:0];
                win_oh  = 5'(1 << i);
            end
        end
        win_vec = VECTOR_BASE + VECTOR_STEP * {5'd0, win_idx};
    end

    always_comb begin
        state_d   = state_q;
        int_req_d = int_req_q;
        vec_d     = vec_q;
        clr       = 5'd0;
        case (state_q)
            IDLE: begin
                int_req_d = 1'b0;
                if (pend != 5'd0) begin
                    state_d   = ARMED;
                    int_req_d = 1'b1;
                    vec_d     = win_vec;
                end
            end
            ARMED: begin
                if (bus.int_cpu_ack) begin
                    clr       = win_oh;
                    int_req_d = 1'b0;
                    state_d   = HOLD;
                end else if (pend == 5'd0) begin
                    int_req_d = 1'b0;
                    state_d   = IDLE;
                end else begin
                    int_req_d = 1'b1;
                    vec_d     = win_vec;
                end
            end
            HOLD: begin
                int_req_d = 1'b0;
                state_d   = IDLE;
            end
            default: begin
                int_req_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    // A new capture outranks both a CPU write and a dispatch clear in the same cycle.
    always_comb begin
        if_d = ((if_wr ? bus.din[4:0] : if_q) & ~clr) | set;
        ie_d = ie_wr ? bus.din : ie_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            if_q      <= 5'd0;
            ie_q      <= 8'd0;
            ack_q     <= 5'd0;
            int_req_q <= 1'b0;
            vec_q     <= VECTOR_BASE;
        end else begin
            state_q   <= state_d;
            if_q      <= if_d;
            ie_q      <= ie_d;
            ack_q     <= ack_d;
            int_req_q <= int_req_d;
            vec_q     <= vec_d;
        end
    end

    always_comb begin
        if (bus.a == IF_ADDR)
            bus.dout = {3'b111, if_q};
        else if (bus.a == IE_ADDR)
            bus.dout = ie_q;
        else
            bus.dout = 8'hFF;
    end

    assign bus.int_req    = int_req_q;
    assign bus.int_vector = vec_q;
    assign irq_ack        = ack_q;

endmodule

// File: tb/tb_interrupt_ctrl.sv
// tb/tb_interrupt_ctrl.sv - directed self-checking bench for interrupt_ctrl
module tb_interrupt_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] irq_src;
    logic [4:0] irq_ack;
    int         tests = 0;
    int         fails = 0;

    localparam logic [15:0] IF_A = 16'hFF0F;
    localparam logic [15:0] IE_A = 16'hFFFF;

    interrupt_ctrl_if bus();

    interrupt_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .irq_src (irq_src),
        .irq_ack (irq_ack)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reg(input string tag, input logic [15:0] addr, input logic [7:0] exp);
        bus.a  = addr;
        bus.rd = 1'b1;
        #1;
        chk(tag, bus.dout, exp);
        bus.rd = 1'b0;
    endtask

    task automatic write(input logic [15:0] addr, input logic [7:0] d);
        bus.a   = addr;
        bus.din = d;
        bus.wr  = 1'b1;
        tick();
        bus.wr  = 1'b0;
        bus.a   = 16'h0000;
    endtask

    task automatic cpu_ack_pulse();
        bus.int_cpu_ack = 1'b1;
        tick();
        bus.int_cpu_ack = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (bus.int_req !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        chk(tag, {7'd0, bus.int_req}, 8'h01);
    endtask

    initial begin
        logic [4:0] rem;
        rst             = 1'b1;
        irq_src         = 5'd0;
        bus.a           = 16'h0000;
        bus.din         = 8'h00;
        bus.rd          = 1'b0;
        bus.wr          = 1'b0;
        bus.int_cpu_ack = 1'b0;
        tick(2);

        chk_reg("rst_if", IF_A, 8'hE0);
        chk_reg("rst_ie", IE_A, 8'h00);
        chk_reg("unmapped", 16'hC000, 8'hFF);
        chk("rst_ack", {3'd0, irq_ack}, 8'h00);
        chk("rst_req", {7'd0, bus.int_req}, 8'h00);
        chk("rst_vec", bus.int_vector, 8'h40);
        rst = 1'b0;
        tick();

        // 1: timer capture latency and vector
        write(IE_A, 8'h04);
        irq_src = 5'h04;
        tick();
        chk("t1_ack", {3'd0, irq_ack}, 8'h04);
        chk_reg("t1_if", IF_A, 8'hE4);
        chk("t1_req0", {7'd0, bus.int_req}, 8'h00);
        irq_src = 5'h00;
        tick();
        chk("t1_ack_pulse", {3'd0, irq_ack}, 8'h00);
        chk("t1_req", {7'd0, bus.int_req}, 8'h01);
        chk("t1_vec", bus.int_vector, 8'h50);
        cpu_ack_pulse();
        chk("t1_req_hold", {7'd0, bus.int_req}, 8'h00);
        chk_reg("t1_if_clr", IF_A, 8'hE0);
        tick(3);

        // 2: all pending, served in priority order
        write(IE_A, 8'h1F);
        write(IF_A, 8'h1F);
        for (int k = 0; k < 5; k++) begin
            rem = 5'h1F & ~((5'd1 << k) - 5'd1);
            wait_req($sformatf("t2_req%0d", k));
            chk($sformatf("t2_vec%0d", k), bus.int_vector, 8'h40 + 8'(8 * k));
            chk_reg($sformatf("t2_if%0d", k), IF_A, {3'b111, rem});
            cpu_ack_pulse();
            chk($sformatf("t2_hold%0d", k), {7'd0, bus.int_req}, 8'h00);
            chk_reg($sformatf("t2_ifc%0d", k), IF_A, {3'b111, rem & ~(5'd1 << k)});
        end
        tick(3);
        chk("t2_done", {7'd0, bus.int_req}, 8'h00);

        // 3: higher-priority arrival replaces armed vector
        irq_src = 5'h04;
        tick();
        irq_src = 5'h00;
        tick();
        chk("t3_vec_tmr", bus.int_vector, 8'h50);
        irq_src = 5'h01;
        tick();
        irq_src = 5'h00;
        tick();
        chk("t3_vec_vbl", bus.int_vector, 8'h40);
        chk("t3_req", {7'd0, bus.int_req}, 8'h01);
        cpu_ack_pulse();
        chk_reg("t3_if", IF_A, 8'hE4);
        wait_req("t3_req2");
        chk("t3_vec2", bus.int_vector, 8'h50);
        cpu_ack_pulse();
        chk_reg("t3_if2", IF_A, 8'hE0);
        tick(3);

        // 4: set beats same-cycle write; IE stores all 8 bits
        irq_src = 5'h08;
        write(IF_A, 8'h00);
        irq_src = 5'h00;
        chk_reg("t4_if", IF_A, 8'hE8);
        write(IE_A, 8'hA5);
        chk_reg("t4_ie", IE_A, 8'hA5);
        tick(2);
        chk("t4_req", {7'd0, bus.int_req}, 8'h00);
        write(IF_A, 8'h00);
        tick(2);

        // 5: IE cleared while armed; ack in IDLE ignored
        write(IE_A, 8'h04);
        write(IF_A, 8'h04);
        tick();
        chk("t5_req", {7'd0, bus.int_req}, 8'h01);
        chk("t5_vec", bus.int_vector, 8'h50);
        write(IE_A, 8'h00);
        tick();
        chk("t5_drop", {7'd0, bus.int_req}, 8'h00);
        cpu_ack_pulse();
        chk_reg("t5_if", IF_A, 8'hE4);

        // 6: reset during ARMED, held joypad recaptured
        write(IE_A, 8'h04);
        tick();
        chk("t6_armed", {7'd0, bus.int_req}, 8'h01);
        irq_src = 5'h10;
        rst     = 1'b1;
        #1;
        chk("t6_req", {7'd0, bus.int_req}, 8'h00);
        chk("t6_vec", bus.int_vector, 8'h40);
        chk("t6_ack", {3'd0, irq_ack}, 8'h00);
        chk_reg("t6_if", IF_A, 8'hE0);
        chk_reg("t6_ie", IE_A, 8'h00);
        tick();
        rst = 1'b0;
        tick();
        chk("t6_cap_ack", {3'd0, irq_ack}, 8'h10);
        chk_reg("t6_cap_if", IF_A, 8'hF0);
        tick();
        chk("t6_ack_gap", {3'd0, irq_ack}, 8'h00);
        tick();
        chk("t6_recap", {3'd0, irq_ack}, 8'h10);
        irq_src = 5'h00;
        tick(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
